// File: rtl/axi_fb_pkg.sv
// Shared types and constants for the AXI write-channel frame buffer.
//   resp_t       : AXI B-channel response codes used by the slave
//   state_t      : write-path FSM states
//   FB_BASE_ADDR : default byte address of buffer word 0
package axi_fb_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] FB_BASE_ADDR = 32'h0000_1000;

endpackage

// File: rtl/fb_dp_ram.sv
// Simple dual-port word RAM for the frame buffer.
//   clk_i                 : clock
//   rst_i                 : synchronous active-high reset; clears only the read register
//   we_i/waddr_i/wdata_i  : write port
//   raddr_i/rdata_o       : registered read port, 1-cycle latency, returns the old word when the
//                           same index is written in the same cycle
module fb_dp_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the array gives read-old-on-collision behaviour.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_slave_frame_buffer.sv
// AXI4 write-channel slave (AW/W/B) that terminates camera INCR bursts into a word buffer and
// exposes a registered read port for the detector.
//   ACLK, ARESET          : clock and synchronous active-high reset
//   AW*, W*, B*           : AXI write address / data / response channels (no WSTRB)
//   rd_addr, rd_data      : detector read port, 1-cycle latency
//   frame_done, frame_cnt : pulse and wrapping count of OKAY bursts
module axi_slave_frame_buffer
  import axi_fb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FB_BASE_ADDR)
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDR_W-1:0]        AWADDR,
  input  logic [7:0]               AWLEN,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic                     WVALID,
  output logic                     WREADY,
  input  logic                     WLAST,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  state_t           state_q, state_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  resp_t            bresp_q, bresp_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       len_q, len_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             err_q, err_d;

  logic             aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0] aw_off;
  logic [ADDR_W:0]  aw_end_idx;
  logic             aw_err;
  logic             beat_is_len;
  logic             last_mismatch;
  logic             mem_we;
  logic [IdxW-1:0]  mem_waddr;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign b_hs  = bvalid_q & BREADY;

  // Range check uses the full-width word offset so an out-of-range start cannot alias into the
  // buffer through truncation of the index.
  assign aw_off     = AWADDR - BASE_ADDR;
  assign aw_end_idx = {3'b000, aw_off[ADDR_W-1:2]} + {{(ADDR_W-7){1'b0}}, AWLEN};
  assign aw_err     = (AWADDR[1:0] != 2'b00) || (AWADDR < BASE_ADDR) ||
                      (aw_end_idx >= (ADDR_W+1)'(DEPTH));

  assign beat_is_len   = (beat_cnt_q == len_q);
  assign last_mismatch = WLAST != beat_is_len;
  assign mem_waddr     = idx_q + IdxW'(beat_cnt_q);

  always_comb begin
    state_d      = state_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    idx_d        = idx_q;
    err_d        = err_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d    = DATA;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          idx_d      = aw_off[IdxW+1:2];
          len_d      = AWLEN;
          beat_cnt_d = 8'd0;
          err_d      = aw_err;
        end
      end
      DATA: begin
        if (w_hs) begin
          // A WLAST mismatch is only known on the terminating beat, so earlier beats land.
          mem_we     = ~err_q;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_is_len || WLAST) begin
            state_d  = RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            err_d    = err_q | last_mismatch;
            bresp_d  = (err_q || last_mismatch) ? SLVERR : OKAY;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          err_d     = 1'b0;
          if (bresp_q == OKAY) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      awready_q    <= 1'b1;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= OKAY;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
      beat_cnt_q   <= 8'd0;
      len_q        <= 8'd0;
      idx_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
    end
  end

  fb_dp_ram #(
    .Depth (DEPTH),
    .Width (DATA_W)
  ) u_ram (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (WDATA),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign AWREADY    = awready_q;
  assign WREADY     = wready_q;
  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_axi_slave_frame_buffer.sv
// Directed self-checking bench for axi_slave_frame_buffer. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_axi_slave_frame_buffer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic        WLAST;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  axi_slave_frame_buffer dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .AWADDR     (AWADDR),
    .AWLEN      (AWLEN),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .WDATA      (WDATA),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .WLAST      (WLAST),
    .BRESP      (BRESP),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, output int waited);
    int n = 0;
    AWADDR  = addr;
    AWLEN   = len;
    AWVALID = 1'b1;
    while (!AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("aw_ready_seen", {31'd0, AWREADY}, 32'd1);
    waited = n;
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic last);
    int n = 0;
    WDATA  = data;
    WLAST  = last;
    WVALID = 1'b1;
    while (!WREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("w_ready_seen", {31'd0, WREADY}, 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  // Holds BREADY low for 'hold' cycles while checking B stays stable, then completes the handshake.
  task automatic wait_b(input int hold, output logic [1:0] resp);
    int n = 0;
    while (!BVALID && n < 40) begin
      @(negedge ACLK);
      n++;
    end
    check("b_valid_seen", {31'd0, BVALID}, 32'd1);
    resp = BRESP;
    for (int i = 0; i < hold; i++) begin
      check("b_hold_valid", {31'd0, BVALID}, 32'd1);
      check("b_hold_resp", {30'd0, BRESP}, {30'd0, resp});
      check("b_hold_awready", {31'd0, AWREADY}, 32'd0);
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("frame_done_pulse", {31'd0, frame_done}, {31'd0, (resp == 2'b00)});
    check("awready_after_b", {31'd0, AWREADY}, 32'd1);
    check("bvalid_after_b", {31'd0, BVALID}, 32'd0);
    @(negedge ACLK);
    check("frame_done_drop", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic rd(input logic [7:0] idx, input logic [31:0] exp, input string tag);
    rd_addr = idx;
    @(negedge ACLK);
    check(tag, rd_data, exp);
  endtask

  initial begin
    int         waited;
    logic [1:0] resp;

    ARESET  = 1'b1;
    AWADDR  = '0;
    AWLEN   = '0;
    AWVALID = 1'b0;
    WDATA   = '0;
    WVALID  = 1'b0;
    WLAST   = 1'b0;
    BREADY  = 1'b0;
    rd_addr = '0;
    repeat (2) @(negedge ACLK);
    check("rst_awready", {31'd0, AWREADY}, 32'd1);
    check("rst_wready", {31'd0, WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_bresp", {30'd0, BRESP}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // 1: aligned 16-beat burst at word 0
    send_aw(32'h1000, 8'd15, waited);
    check("t1_wready_after_aw", {31'd0, WREADY}, 32'd1);
    for (int i = 0; i < 16; i++) send_w(32'hABC0_0000 + i, i == 15);
    check("t1_bvalid_next", {31'd0, BVALID}, 32'd1);
    wait_b(0, resp);
    check("t1_resp", {30'd0, resp}, 32'd0);
    check("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    for (int i = 0; i < 16; i++) rd(8'(i), 32'hABC0_0000 + i, "t1_rd");

    // 2: misaligned address, beats consumed but not written
    send_aw(32'h1002, 8'd3, waited);
    for (int i = 0; i < 4; i++) send_w(32'hDEAD_0000 + i, i == 3);
    wait_b(0, resp);
    check("t2_resp", {30'd0, resp}, 32'd2);
    check("t2_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    for (int i = 0; i < 4; i++) rd(8'(i), 32'hABC0_0000 + i, "t2_rd_unchanged");

    // 3: burst running past the end (idx 252 + 7); a wrapped write would hit words 0..3
    send_aw(32'h13F0, 8'd7, waited);
    for (int i = 0; i < 8; i++) send_w(32'hBEEF_0000 + i, i == 7);
    wait_b(0, resp);
    check("t3_resp", {30'd0, resp}, 32'd2);
    check("t3_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    for (int i = 0; i < 4; i++) rd(8'(i), 32'hABC0_0000 + i, "t3_rd_unchanged");

    // 4: early WLAST on beat 9 of a 16-beat burst
    send_aw(32'h1000, 8'd15, waited);
    for (int i = 0; i < 10; i++) send_w(32'h4444_0000 + i, i == 9);
    check("t4_wready_closed", {31'd0, WREADY}, 32'd0);
    check("t4_bvalid", {31'd0, BVALID}, 32'd1);
    wait_b(0, resp);
    check("t4_resp", {30'd0, resp}, 32'd2);
    check("t4_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    for (int i = 0; i < 10; i++) rd(8'(i), 32'h4444_0000 + i, "t4_rd_written");
    rd(8'd10, 32'hABC0_000A, "t4_rd_word10");

    // 5: BREADY held low, then back-to-back AW right after the B handshake
    send_aw(32'h1100, 8'd0, waited);
    send_w(32'h5555_5555, 1'b1);
    wait_b(5, resp);
    check("t5_resp", {30'd0, resp}, 32'd0);
    check("t5_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    send_aw(32'h1104, 8'd0, waited);
    check("t5_aw_no_wait", waited, 32'd0);
    send_w(32'h6666_6666, 1'b1);
    wait_b(0, resp);
    check("t5_resp2", {30'd0, resp}, 32'd0);
    check("t5_frame_cnt2", {16'd0, frame_cnt}, 32'd3);
    rd(8'd64, 32'h5555_5555, "t5_rd64");
    rd(8'd65, 32'h6666_6666, "t5_rd65");

    // 6: reset after beat 7 of a 16-beat burst, then a clean burst
    send_aw(32'h1200, 8'd15, waited);
    for (int i = 0; i < 8; i++) send_w(32'h7777_0000 + i, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check("t6_awready", {31'd0, AWREADY}, 32'd1);
    check("t6_wready", {31'd0, WREADY}, 32'd0);
    check("t6_bvalid", {31'd0, BVALID}, 32'd0);
    check("t6_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("t6_rd_data", rd_data, 32'd0);
    send_aw(32'h1200, 8'd3, waited);
    for (int i = 0; i < 4; i++) send_w(32'h8888_0000 + i, i == 3);
    wait_b(0, resp);
    check("t6_resp", {30'd0, resp}, 32'd0);
    check("t6_frame_cnt2", {16'd0, frame_cnt}, 32'd1);
    for (int i = 0; i < 4; i++) rd(8'(128 + i), 32'h8888_0000 + i, "t6_rd_new");
    for (int i = 4; i < 8; i++) rd(8'(128 + i), 32'h7777_0000 + i, "t6_rd_kept");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
